// File: rtl/mop_queue_pkg.sv
// Shared micro-op types for the cracker -> mop_queue -> rename path.
// The queue and its bench both size against MAX_MOP_CNT from here.
package mop_queue_pkg;

  localparam int MAX_MOP_CNT = 8;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] imm;
  } micro_op_t;

  typedef micro_op_t [0:MAX_MOP_CNT-1] mop_bundle_t;
  typedef logic [3:0] mop_cnt_t;

endpackage

// File: rtl/mop_queue.sv
// Circular micro-op queue between the cracker and rename/issue.
// Accepts up to MAX_MOP_CNT mops per cycle and issues one mop per cycle, in order.
module mop_queue
  import mop_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  mop_cnt_t          in_cnt,
  input  mop_bundle_t       in_mops,
  output logic              in_ready,
  output logic              out_valid,
  output micro_op_t         out_mop,
  output logic              out_last,
  input  logic              out_ready,
  output logic [PTR_W:0]    occupancy,
  output logic              err
);

  typedef logic [PTR_W:0] cnt_t;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  micro_op_t        mem [DEPTH];
  logic [DEPTH-1:0] last_bits;

  logic     bad_cnt;
  logic     enq_fire;
  logic     deq_fire;
  mop_cnt_t enq_cnt;
  cnt_t     occ_nxt;

  // Readiness looks only at state so a worst-case bundle always fits.
  assign in_ready  = !reset && !flush &&
                     ((cnt_t'(DEPTH) - occupancy) >= cnt_t'(MAX_MOP_CNT));
  assign bad_cnt   = in_cnt > mop_cnt_t'(MAX_MOP_CNT);
  assign enq_fire  = in_valid && in_ready;
  assign enq_cnt   = (enq_fire && !bad_cnt) ? in_cnt : '0;

  assign out_valid = !reset && !flush && (occupancy != '0);
  assign deq_fire  = out_valid && out_ready;
  assign out_mop   = mem[head];
  assign out_last  = last_bits[head];

  assign occ_nxt   = occupancy + cnt_t'(enq_cnt) - cnt_t'(deq_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      err       <= 1'b0;
      last_bits <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      head      <= head + PTR_W'(deq_fire);
      tail      <= tail + PTR_W'(enq_cnt);
      occupancy <= occ_nxt;
      err       <= err | (enq_fire && bad_cnt);
      for (int i = 0; i < MAX_MOP_CNT; i++) begin
        if (mop_cnt_t'(i) < enq_cnt)
          last_bits[tail + PTR_W'(i)] <= (mop_cnt_t'(i) == (enq_cnt - mop_cnt_t'(1)));
      end
    end
  end

  // Payload storage carries no reset; enq_cnt is already zero under reset/flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_MOP_CNT; i++) begin
      if (mop_cnt_t'(i) < enq_cnt)
        mem[tail + PTR_W'(i)] <= in_mops[i];
    end
  end

endmodule

// File: tb/tb_mop_queue.sv
// Directed bench for mop_queue: ordering, last tagging, full/empty, wrap,
// concurrent enq/deq, flush and malformed-bundle error.
module tb_mop_queue;
  import mop_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  mop_cnt_t        in_cnt;
  mop_bundle_t     in_mops;
  logic            in_ready;
  logic            out_valid;
  micro_op_t       out_mop;
  logic            out_last;
  logic            out_ready;
  logic [PTR_W:0]  occupancy;
  logic            err;

  int n_assert = 0;
  int n_fail   = 0;

  mop_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_cnt    (in_cnt),
    .in_mops   (in_mops),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_mop   (out_mop),
    .out_last  (out_last),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bundle(input logic [7:0] base, input int cnt);
    in_valid = 1'b1;
    in_cnt   = mop_cnt_t'(cnt);
    for (int i = 0; i < MAX_MOP_CNT; i++) begin
      in_mops[i].opcode = base + 8'(i);
      in_mops[i].imm    = 8'(i);
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_cnt    = '0;
    in_mops   = '0;
    out_ready = 1'b0;

    // reset held two cycles
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_occ", 32'(occupancy), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);

    // one bundle of five, streamed straight out
    out_ready = 1'b1;
    drive_bundle(8'hA0, 5);
    chk("pre_enq_out_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("b5_occ", 32'(occupancy), 32'(5 - k));
      chk("b5_valid", 32'(out_valid), 32'd1);
      chk("b5_op", 32'(out_mop.opcode), 32'(8'hA0 + k));
      chk("b5_last", 32'(out_last), 32'(k == 4));
      step();
    end
    chk("b5_empty_occ", 32'(occupancy), 32'd0);
    chk("b5_empty_valid", 32'(out_valid), 32'd0);

    // fill to DEPTH with two bundles of eight
    out_ready = 1'b0;
    drive_bundle(8'hB0, 8);
    step();
    chk("fill8_occ", 32'(occupancy), 32'd8);
    chk("fill8_in_ready", 32'(in_ready), 32'd1);
    drive_bundle(8'hC0, 8);
    step();
    drive_bundle(8'hD0, 2);
    chk("full_occ", 32'(occupancy), 32'd16);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("full_hold_occ", 32'(occupancy), 32'd16);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_b_op", 32'(out_mop.opcode), 32'(8'hB0 + k));
      chk("drain_b_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    chk("half_occ", 32'(occupancy), 32'd8);
    chk("half_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("drain_c_op", 32'(out_mop.opcode), 32'(8'hC0 + k));
      chk("drain_c_last", 32'(out_last), 32'(k == 7));
      step();
    end
    chk("drained_occ", 32'(occupancy), 32'd0);
    chk("drained_valid", 32'(out_valid), 32'd0);

    // head/tail sit at 5: push nine more to reach 14, then drain
    out_ready = 1'b0;
    drive_bundle(8'hE0, 8);
    step();
    drive_bundle(8'hF0, 1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("adv_op", 32'(out_mop.opcode), (k < 8) ? 32'(8'hE0 + k) : 32'h0000_00F0);
      chk("adv_last", 32'(out_last), 32'(k >= 7));
      step();
    end
    chk("adv_occ", 32'(occupancy), 32'd0);

    // P..T across the wrap from entry 14
    out_ready = 1'b0;
    drive_bundle(8'h50, 5);
    step();
    in_valid = 1'b0;
    chk("wrap_occ", 32'(occupancy), 32'd5);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("wrap_op", 32'(out_mop.opcode), 32'(8'h50 + k));
      chk("wrap_last", 32'(out_last), 32'(k == 4));
      step();
    end
    chk("wrap_empty", 32'(occupancy), 32'd0);

    // concurrent enqueue of three and dequeue of one at occupancy 4
    out_ready = 1'b0;
    drive_bundle(8'h60, 4);
    step();
    chk("cc_occ4", 32'(occupancy), 32'd4);
    chk("cc_head", 32'(out_mop.opcode), 32'h60);
    drive_bundle(8'h70, 3);
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("cc_occ6", 32'(occupancy), 32'd6);
    chk("cc_next", 32'(out_mop.opcode), 32'h61);

    // flush with a bundle presented
    flush = 1'b1;
    drive_bundle(8'h80, 4);
    out_ready = 1'b1;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("flushed_occ", 32'(occupancy), 32'd0);
    chk("flushed_valid", 32'(out_valid), 32'd0);
    drive_bundle(8'h90, 1);
    step();
    in_valid = 1'b0;
    chk("post_flush_occ", 32'(occupancy), 32'd1);
    chk("post_flush_op", 32'(out_mop.opcode), 32'h90);
    chk("post_flush_last", 32'(out_last), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_flush_empty", 32'(occupancy), 32'd0);

    // zero-count handshake, then malformed bundle
    drive_bundle(8'h40, 2);
    step();
    drive_bundle(8'h48, 0);
    step();
    chk("zero_cnt_occ", 32'(occupancy), 32'd2);
    drive_bundle(8'h4C, 9);
    step();
    in_valid = 1'b0;
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_occ", 32'(occupancy), 32'd2);
    chk("bad_head", 32'(out_mop.opcode), 32'h40);
    step();
    chk("err_sticky", 32'(err), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("err_after_flush", 32'(err), 32'd1);
    chk("occ_after_flush", 32'(occupancy), 32'd0);

    // reset in the middle of traffic
    drive_bundle(8'h30, 3);
    step();
    in_valid = 1'b0;
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    reset     = 1'b1;
    out_ready = 1'b1;
    drive_bundle(8'h38, 2);
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
